// File: rtl/cpu_ctrl_seq.sv
// Hardwired beat sequencer and opcode decoder for the 8-bit model CPU.
// Optional single-step WAIT state is enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl_seq #(
    parameter int unsigned ILLEGAL_HALT = 0,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [3:0]       OPCODE_IN,
`ifdef CPU_CTRL_STEP_EN
    input  logic             STEP,
`endif
    output logic [7:0]       T,
    output logic             HALT,
    output logic             LD,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             SHL,
    output logic             XOR,
    output logic             ROM_OE,
    output logic             ABUS_SEL,
    output logic             IR_LD,
    output logic             PC_INC,
    output logic             DR_LD,
    output logic             ACC_LD,
    output logic [2:0]       ALU_OP,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_CNT
);

`ifdef CPU_CTRL_STEP_EN
    typedef enum logic [1:0] {S_RUN, S_HALTED, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_HALTED} state_t;
`endif

    state_t             state_q, state_d;
    logic [2:0]         beat_q, beat_d;
    logic [7:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               operandOp;
    logic               aluOp;
    logic [2:0]         aluCode;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_RUN;
            beat_q  <= 3'd0;
            flags_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // flags_q holds one bit per opcode (bit n = opcode n); illegal opcodes map to HALT or to nothing.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd1) begin
                    if (OPCODE_IN[3])
                        flags_d = (ILLEGAL_HALT != 0) ? 8'h01 : 8'h00;
                    else
                        flags_d = 8'h01 << OPCODE_IN[2:0];
                end
                if (beat_q == 3'd2 && flags_q[0]) begin
                    state_d = S_HALTED;
                    beat_d  = 3'd0;
                end
                if (beat_q == 3'd7) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CPU_CTRL_STEP_EN
                    state_d = S_WAIT;
`endif
                end
            end
`ifdef CPU_CTRL_STEP_EN
            S_WAIT: begin
                if (STEP) begin
                    state_d = S_RUN;
                    beat_d  = 3'd0;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign operandOp = |(flags_q & 8'hBE);
    assign aluOp     = |(flags_q & 8'hFE);

    always_comb begin
        aluCode = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (flags_q[k])
                aluCode = 3'(k - 1);
        end
    end

    // Strobes are pure decode of beat and flags, so reset shows the T0 fetch strobes.
    always_comb begin
        T        = 8'h00;
        ROM_OE   = 1'b0;
        ABUS_SEL = 1'b0;
        IR_LD    = 1'b0;
        PC_INC   = 1'b0;
        DR_LD    = 1'b0;
        ACC_LD   = 1'b0;
        ALU_OP   = 3'd0;
        if (state_q == S_RUN) begin
            T = 8'h01 << beat_q;
            case (beat_q)
                3'd0: ROM_OE = 1'b1;
                3'd1: begin
                    IR_LD  = 1'b1;
                    PC_INC = 1'b1;
                end
                3'd3: begin
                    ROM_OE   = operandOp;
                    ABUS_SEL = operandOp;
                end
                3'd4: DR_LD = operandOp;
                3'd5: begin
                    ACC_LD = aluOp;
                    ALU_OP = aluOp ? aluCode : 3'd0;
                end
                default: begin
                    ROM_OE = 1'b0;
                end
            endcase
        end
    end

    assign HALT      = flags_q[0];
    assign LD        = flags_q[1];
    assign ADD       = flags_q[2];
    assign SUB       = flags_q[3];
    assign AND       = flags_q[4];
    assign OR        = flags_q[5];
    assign SHL       = flags_q[6];
    assign XOR       = flags_q[7];
    assign HALTED    = (state_q == S_HALTED);
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: per-beat expectations are queued by the stimulus
// and popped by a negedge monitor. Exercises the STEP port when CPU_CTRL_STEP_EN is defined.
module tb_cpu_ctrl_seq;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic [3:0] OPCODE_IN;
`ifdef CPU_CTRL_STEP_EN
    logic       STEP;
`endif

    logic [7:0] t1, t2;
    logic       halt1, ld1, add1, sub1, and1, or1, shl1, xor1;
    logic       halt2, ld2, add2, sub2, and2, or2, shl2, xor2;
    logic       romOe1, abusSel1, irLd1, pcInc1, drLd1, accLd1;
    logic       romOe2, abusSel2, irLd2, pcInc2, drLd2, accLd2;
    logic [2:0] aluOp1, aluOp2;
    logic       halted1, halted2;
    logic [7:0] cnt1, cnt2;

    typedef struct {
        logic [7:0] t;
        logic [7:0] flags;
        logic [5:0] strb;
        logic [2:0] alu;
        logic       halted;
        logic [7:0] cnt;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monEntry;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] expCnt;
    logic [7:0] prevFlags;

    always #5 CLK = ~CLK;

    cpu_ctrl_seq #(.ILLEGAL_HALT(0), .CNT_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn), .OPCODE_IN(OPCODE_IN),
`ifdef CPU_CTRL_STEP_EN
        .STEP(STEP),
`endif
        .T(t1), .HALT(halt1), .LD(ld1), .ADD(add1), .SUB(sub1), .AND(and1), .OR(or1),
        .SHL(shl1), .XOR(xor1), .ROM_OE(romOe1), .ABUS_SEL(abusSel1), .IR_LD(irLd1),
        .PC_INC(pcInc1), .DR_LD(drLd1), .ACC_LD(accLd1), .ALU_OP(aluOp1),
        .HALTED(halted1), .INSTR_CNT(cnt1)
    );

    // Second copy sees the same stimulus but treats illegal opcodes as HALT.
    cpu_ctrl_seq #(.ILLEGAL_HALT(1), .CNT_W(8)) dutIh (
        .CLK(CLK), .RESETn(RESETn), .OPCODE_IN(OPCODE_IN),
`ifdef CPU_CTRL_STEP_EN
        .STEP(STEP),
`endif
        .T(t2), .HALT(halt2), .LD(ld2), .ADD(add2), .SUB(sub2), .AND(and2), .OR(or2),
        .SHL(shl2), .XOR(xor2), .ROM_OE(romOe2), .ABUS_SEL(abusSel2), .IR_LD(irLd2),
        .PC_INC(pcInc2), .DR_LD(drLd2), .ACC_LD(accLd2), .ALU_OP(aluOp2),
        .HALTED(halted2), .INSTR_CNT(cnt2)
    );

    function automatic logic [7:0] flagsOf(input logic [3:0] op);
        if (op[3]) return 8'h00;
        return 8'h01 << op[2:0];
    endfunction

    function automatic logic [2:0] aluCodeOf(input logic [3:0] op);
        case (op)
            4'd1: return 3'd0;
            4'd2: return 3'd1;
            4'd3: return 3'd2;
            4'd4: return 3'd3;
            4'd5: return 3'd4;
            4'd6: return 3'd5;
            4'd7: return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // strb = {ROM_OE, ABUS_SEL, IR_LD, PC_INC, DR_LD, ACC_LD}
    function automatic exp_t beatEntry(input logic [3:0] op, input int b,
                                       input logic [7:0] prev, input logic [7:0] cnt);
        exp_t e;
        logic operand;
        logic usesAlu;
        operand  = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7});
        usesAlu  = (op inside {[4'd1:4'd7]});
        e.t      = 8'h01 << b;
        e.flags  = (b >= 2) ? flagsOf(op) : prev;
        e.strb   = 6'b000000;
        e.alu    = 3'd0;
        e.halted = 1'b0;
        e.cnt    = cnt;
        case (b)
            0: e.strb = 6'b100000;
            1: e.strb = 6'b001100;
            3: if (operand) e.strb = 6'b110000;
            4: if (operand) e.strb = 6'b000010;
            5: if (usesAlu) begin
                e.strb = 6'b000001;
                e.alu  = aluCodeOf(op);
            end
            default: e.strb = 6'b000000;
        endcase
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("T", 32'(t1), 32'(e.t));
        cmp("flags", 32'({xor1, shl1, or1, and1, sub1, add1, ld1, halt1}), 32'(e.flags));
        cmp("strobes", 32'({romOe1, abusSel1, irLd1, pcInc1, drLd1, accLd1}), 32'(e.strb));
        cmp("ALU_OP", 32'(aluOp1), 32'(e.alu));
        cmp("HALTED", 32'(halted1), 32'(e.halted));
        cmp("INSTR_CNT", 32'(cnt1), 32'(e.cnt));
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            checkOutput(monEntry);
        end
    end

    task automatic doReset();
        exp_t e;
        RESETn = 1'b0;
        #1;
        cmp("resetImmediateT", 32'(t1), 32'h01);
        cmp("resetImmediateAccLd", 32'(accLd1), 32'h0);
        e.t = 8'h01; e.flags = 8'h00; e.strb = 6'b100000;
        e.alu = 3'd0; e.halted = 1'b0; e.cnt = 8'h00;
        expQ.push_back(e);
        expCnt    = 8'h00;
        prevFlags = 8'h00;
        @(negedge CLK);
        @(posedge CLK);
        #1 RESETn = 1'b1;
    endtask

    // Called one step after a rising edge with the DUT in T0. Partial (non-HALT) runs stop mid-last-beat.
    task automatic applyStimulus(input logic [3:0] op, input int nBeats, input int waitCycles);
        exp_t e;
        OPCODE_IN = op;
        for (int b = 0; b < nBeats; b++)
            expQ.push_back(beatEntry(op, b, prevFlags, expCnt));
        if (op == 4'd0 && nBeats >= 3) begin
            e.t = 8'h00; e.flags = 8'h01; e.strb = 6'b000000;
            e.alu = 3'd0; e.halted = 1'b1; e.cnt = expCnt;
            for (int k = 0; k < waitCycles; k++) expQ.push_back(e);
        end else if (nBeats == 8) begin
            expCnt = expCnt + 8'd1;
`ifdef CPU_CTRL_STEP_EN
            e.t = 8'h00; e.flags = flagsOf(op); e.strb = 6'b000000;
            e.alu = 3'd0; e.halted = 1'b0; e.cnt = expCnt;
            for (int k = 0; k < waitCycles; k++) expQ.push_back(e);
`endif
        end
        if (nBeats > 2) prevFlags = flagsOf(op);

        if (op != 4'd0 && nBeats < 8) begin
            for (int b = 0; b < nBeats - 1; b++) begin
                @(posedge CLK);
                #1;
                if (b == 1) OPCODE_IN = 4'h0;
            end
            #7;
        end else begin
            for (int b = 0; b < nBeats; b++) begin
                @(posedge CLK);
                #1;
                if (b == 1) OPCODE_IN = 4'h0;
            end
            if (op == 4'd0) begin
                repeat (waitCycles) begin
                    @(posedge CLK);
                    #1;
                end
            end else begin
`ifdef CPU_CTRL_STEP_EN
                for (int k = 0; k < waitCycles; k++) begin
                    STEP = (k == waitCycles - 1);
                    @(posedge CLK);
                    #1;
                end
                STEP = 1'b1;
`endif
            end
        end
    endtask

    initial begin
        int guard;
        RESETn    = 1'b1;
        OPCODE_IN = 4'h0;
        expCnt    = 8'h00;
        prevFlags = 8'h00;
`ifdef CPU_CTRL_STEP_EN
        STEP      = 1'b1;
`endif
        #2;
        doReset();

        applyStimulus(4'd1, 8, 1);
        applyStimulus(4'd6, 8, 1);
        applyStimulus(4'hC, 8, 1);
        cmp("illegalHaltT", 32'(t2), 32'h00);
        cmp("illegalHaltHALTED", 32'(halted2), 32'h1);
        cmp("illegalHaltFlag", 32'(halt2), 32'h1);
        cmp("illegalHaltCnt", 32'(cnt2), 32'h2);

        applyStimulus(4'd2, 8, 1);
        applyStimulus(4'd0, 3, 50);
        doReset();

        applyStimulus(4'd2, 8, 1);
        applyStimulus(4'd2, 5, 0);
        doReset();

        for (int i = 0; i < 255; i++) applyStimulus(4'd7, 8, 1);
        applyStimulus(4'd7, 8, 4);
        applyStimulus(4'd3, 8, 1);

        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Hardwired control sequencer for the 8-bit model CPU (4-bit PC/ABUS, 8-bit ROM data, ACC, DR).
- Generates the one-hot beat signals T0..T7.
- Latches and decodes the opcode nibble fetched from ROM.
- Drives the datapath load/enable strobes and the ALU function select, and counts retired instructions.
- Sits between the ROM/IR fetch path and the PC/DR/ACC/ALU datapath; it is the only source of datapath control.

Parameters:
- ILLEGAL_HALT, 0, 1: opcodes 8..15 behave as HALT; 0: they execute as NOP.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- OPCODE_IN  in  4  ROM data bits [7:4]; sampled on the edge ending T1.
- T  out  8  one-hot beat; bit n = Tn.
- HALT, LD, ADD, SUB, AND, OR, SHL, XOR  out  1 each  decoded-opcode flags, one-hot or all 0.
- ROM_OE  out  1  ROM output enable.
- ABUS_SEL  out  1  ABUS source: 0 = PC, 1 = IR address field.
- IR_LD  out  1  load IR from DBUS_rom.
- PC_INC  out  1  increment PC.
- DR_LD  out  1  load DR.
- ACC_LD  out  1  load ACC from ALU.
- ALU_OP  out  3  ALU function: 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 XOR.
- HALTED  out  1  sequencer stopped.
- INSTR_CNT  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode map: 0 HALT, 1 LD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SHL, 7 XOR, 8..15 illegal (handled per ILLEGAL_HALT).
- Reset values:
  - beat register = T0, so T = 8'h01.
  - op register and all decoded flags = 0.
  - HALTED = 0; INSTR_CNT = 0.
- Strobes are combinational functions of the beat and the op flags. In reset they therefore show T0 values: ROM_OE = 1, ABUS_SEL = 0, all others 0.
- FSM states: RUN (beat T0..T7), HALTED, and WAIT (only with the optional feature).
- RUN advances one beat per clock; T7 -> T0.
- Per-beat actions:
  - T0: ABUS_SEL = 0, ROM_OE = 1 (instruction fetch).
  - T1: IR_LD = 1, PC_INC = 1. The edge ending T1 latches OPCODE_IN into the op register.
  - T2: decode; flags now valid. Flags hold until the next T1-ending edge.
  - T3: for operand ops (LD, ADD, SUB, AND, OR, XOR): ABUS_SEL = 1, ROM_OE = 1.
  - T4: for operand ops: DR_LD = 1.
  - T5: for LD/ADD/SUB/AND/OR/SHL/XOR: ACC_LD = 1 with ALU_OP per the map. ALU_OP = 0 in all other beats.
  - T6: no strobes.
  - T7: no strobes; the edge ending T7 increments INSTR_CNT (modulo 2^CNT_W, wraps to 0).
- SHL takes no operand: no ROM_OE, ABUS_SEL or DR_LD at T3/T4.
- NOP (illegal opcode with ILLEGAL_HALT = 0):
  - full 8 beats, only the T0/T1 fetch strobes.
  - all flags 0.
  - counted as retired.
- HALT (or illegal opcode with ILLEGAL_HALT = 1):
  - HALT flag = 1 during T2; the edge ending T2 enters HALTED.
  - In HALTED: T = 0, all strobes 0, HALT = 1, HALTED = 1, INSTR_CNT frozen (HALT is not counted).
  - Exit from HALTED is by reset only.
- Reset asserted mid-instruction: all state returns to reset values immediately, with no completion of pending strobes. The first cycle after release is T0.
- OPCODE_IN is ignored outside the T1-ending edge.

Optional Feature:
Macro CPU_CTRL_STEP_EN.
- Defined:
  - adds input port STEP (1 bit).
  - the edge ending T7 enters WAIT instead of T0: T = 0, all strobes 0, HALTED = 0.
  - WAIT moves to T0 on the first rising edge where STEP = 1; STEP held high steps once per instruction.
  - INSTR_CNT still increments at T7.
  - HALT overrides WAIT.
- Not defined: no STEP port and no WAIT state; T7 -> T0 directly.

Test Plan:
1. Release reset, OPCODE_IN = 1 (LD):
   - T walks 01, 02, 04 ... 80 on consecutive cycles.
   - ROM_OE high at T0 and T3; ABUS_SEL = 1 at T3.
   - IR_LD and PC_INC at T1; DR_LD at T4; ACC_LD at T5 with ALU_OP = 0.
   - LD = 1 from T2; INSTR_CNT = 1 after cycle 8.
2. OPCODE_IN = 6 (SHL): no ROM_OE at T3, no DR_LD; ACC_LD at T5 with ALU_OP = 5; SHL = 1.
3. OPCODE_IN = 0 (HALT): HALT = 1 at T2; from the next cycle T = 00 and HALTED = 1 for 50 cycles, no strobes, INSTR_CNT unchanged. Reset recovers to T = 01.
4. OPCODE_IN = 4'hC:
   - ILLEGAL_HALT = 0: 8 beats, no ACC_LD/DR_LD, all flags 0, INSTR_CNT += 1.
   - ILLEGAL_HALT = 1: halts as in scenario 3.
5. Run ADD (ADD = 1, ACC_LD at T5 with ALU_OP = 1), then assert RESETn = 0 mid-T4 of an ADD: ACC_LD never asserts, INSTR_CNT = 0, T = 01 immediately; after release, fetch restarts at T0.
6. Run 256 XOR instructions (ALU_OP = 6 at T5 each time): INSTR_CNT wraps to 0. With CPU_CTRL_STEP_EN: T = 00 after T7 until STEP pulses, then T0 on the next cycle.
